// File: rtl/led_pattern_sequencer.sv
// LED bank pattern sequencer: bus-written register file plus an IDLE/RUN/DONE stepper
// that walks static/rotate/bounce/count patterns at a prescaled rate.
module led_pattern_sequencer #(
  parameter int unsigned             NLEDS       = 5,
  parameter int unsigned             DIV_W       = 24,
  parameter logic [DIV_W-1:0]        DEFAULT_DIV = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic [NLEDS-1:0] leds,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d, os_q, os_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
  logic [NLEDS-1:0] pat_q, pat_d, work_q, work_d, adv_work;
  logic [15:0]      steps_q, steps_d, cnt_q, cnt_d;
  logic             dir_q, dir_d, adv_dir;
  logic             ctrl_wr, start;

  assign ctrl_wr = cfg_we && (cfg_addr == 2'd0);
  assign start   = ctrl_wr && cfg_wdata[4] && cfg_wdata[0];

  assign leds = work_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // One pattern step from the current work value, mode and bounce direction.
  always_comb begin
    adv_work = work_q;
    adv_dir  = dir_q;
    case (mode_q)
      2'd1: adv_work = {work_q[NLEDS-2:0], work_q[NLEDS-1]};
      2'd2: begin
        if (!dir_q) begin
          if (work_q[NLEDS-1]) begin
            adv_work = work_q >> 1;
            adv_dir  = 1'b1;
          end else begin
            adv_work = work_q << 1;
          end
        end else begin
          if (work_q[0]) begin
            adv_work = work_q << 1;
            adv_dir  = 1'b0;
          end else begin
            adv_work = work_q >> 1;
          end
        end
      end
      2'd3:    adv_work = work_q + NLEDS'(1);
      default: adv_work = work_q;
    endcase
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[6:0] = {done, busy, 1'b0, os_q, mode_q, en_q};
      2'd1:    cfg_rdata[DIV_W-1:0] = div_q;
      2'd2:    cfg_rdata[NLEDS-1:0] = pat_q;
      default: cfg_rdata[15:0] = steps_q;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    os_d    = os_q;
    div_d   = div_q;
    pat_d   = pat_q;
    steps_d = steps_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          en_d   = cfg_wdata[0];
          mode_d = cfg_wdata[2:1];
          os_d   = cfg_wdata[3];
        end
        2'd1:    div_d   = cfg_wdata[DIV_W-1:0];
        2'd2:    pat_d   = cfg_wdata[NLEDS-1:0];
        default: steps_d = cfg_wdata[15:0];
      endcase
    end
  end

  // Control writes take priority over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (start) begin
      state_d = S_RUN;
      work_d  = pat_q;
      presc_d = div_q;
      cnt_d   = steps_q;
      dir_d   = 1'b0;
    end else if (ctrl_wr && (state_q == S_DONE || (state_q == S_RUN && !cfg_wdata[0]))) begin
      state_d = S_IDLE;
      work_d  = pat_q;
    end else begin
      case (state_q)
        S_IDLE: work_d = pat_q;
        S_RUN: begin
          if (presc_q == '0) begin
            presc_d = div_q;
            if (os_q && cnt_q == 16'd0) begin
              state_d = S_DONE;
            end else begin
              work_d = adv_work;
              dir_d  = adv_dir;
              if (os_q) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = S_DONE;
              end
            end
          end else begin
            presc_d = presc_q - DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      mode_q  <= 2'd0;
      os_q    <= 1'b0;
      div_q   <= DEFAULT_DIV;
      pat_q   <= NLEDS'(1);
      steps_q <= '0;
      work_q  <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      os_q    <= os_d;
      div_q   <= div_d;
      pat_q   <= pat_d;
      steps_q <= steps_d;
      work_q  <= work_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: register table, spec corner sequences, and randomized
// runs checked against an arithmetic model of the pattern walk.
module tb_led_pattern_sequencer;
  localparam int NL = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic [NL-1:0] leds;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  led_pattern_sequencer #(.NLEDS(NL), .DIV_W(24), .DEFAULT_DIV(24'd5)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .leds(leds), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_leds;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  // Expected LED value t cycles after the start write (t=1 shows the loaded pattern).
  function automatic int model_leds(int mode, int pat, int div, bit os, int steps, int t);
    int k, p, q, r;
    k = (t - 1) / (div + 1);
    if (os && k > steps) k = steps;
    case (mode)
      1: begin
        r = k % NL;
        return ((pat << r) | (pat >> (NL - r))) & 31;
      end
      2: begin
        if (pat == 0) return 0;
        p = 0;
        for (int i = 0; i < NL; i++) if (pat == (1 << i)) p = i;
        q = (p + k) % (2 * (NL - 1));
        return 1 << ((q <= NL - 1) ? q : 2 * (NL - 1) - q);
      end
      3: return (pat + k) % 32;
      default: return pat;
    endcase
  endfunction

  function automatic bit model_done(bit os, int div, int steps, int t);
    int s;
    s = (steps > 0) ? steps : 1;
    return os && (t >= s * (div + 1) + 1);
  endfunction

  task automatic run_check(input string name, input int mode, input int pat, input int div,
                           input bit os, input int steps, input int ncyc);
    wr(2'd1, 32'(div));
    wr(2'd2, 32'(pat));
    wr(2'd3, 32'(steps));
    wr(2'd0, 32'h11 | 32'(mode << 1) | (os ? 32'h8 : 32'h0));
    for (int t = 1; t <= ncyc; t++) begin
      chk({name, " leds"}, 32'(leds), 32'(model_leds(mode, pat, div, os, steps, t)));
      chk({name, " done"}, 32'(done), 32'(model_done(os, div, steps, t)));
      chk({name, " busy"}, 32'(busy), 32'(!model_done(os, div, steps, t)));
      @(negedge clk);
    end
  endtask

  vec_t vecs[12];
  int exp_seq[6];

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0,        5'h01};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h5,        5'h01};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h1,        5'h01};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0,        5'h01};
    vecs[4]  = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h00FFFFFF, 5'h01};
    vecs[5]  = '{1'b1, 2'd2, 32'hFFFFFFF5, 32'h15,       5'h01};
    vecs[6]  = '{1'b1, 2'd3, 32'hABCD1234, 32'h1234,     5'h15};
    vecs[7]  = '{1'b1, 2'd0, 32'hFFFFFFFE, 32'h0E,       5'h15};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,        32'h0E,       5'h15};
    vecs[9]  = '{1'b1, 2'd1, 32'h0,        32'h0,        5'h15};
    vecs[10] = '{1'b1, 2'd2, 32'h1,        32'h1,        5'h15};
    vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h1,        5'h01};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk("post_reset leds", 32'(leds), 32'h0);
    chk("post_reset busy", 32'(busy), 32'h0);
    chk("post_reset done", 32'(done), 32'h0);

    for (int i = 0; i < 12; i++) begin
      cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
      @(negedge clk);
      cfg_we = 1'b0;
      chk($sformatf("vec%0d rdata", i), cfg_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
    end

    run_check("rotate", 1, 1, 0, 1'b0, 0, 8);
    run_check("bounce", 2, 1, 0, 1'b0, 0, 12);
    run_check("count_os", 3, 5'b11110, 0, 1'b1, 3, 25);
    rd_chk("done ctrl read", 2'd0, 32'h4F);
    run_check("count_restart", 3, 5'b11110, 0, 1'b1, 3, 3);
    run_check("rot_div2", 1, 1, 2, 1'b0, 0, 12);
    run_check("os_steps0", 1, 5'b00110, 0, 1'b1, 0, 6);

    // Non-start CTRL write in DONE returns to IDLE.
    wr(2'd0, 32'h3);
    chk("done_clear busy", 32'(busy), 32'h0);
    chk("done_clear done", 32'(done), 32'h0);
    @(negedge clk);
    chk("done_clear leds", 32'(leds), 32'h06);

    // DIV=0 written mid-run only takes effect after the pending reload.
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h13);
    exp_seq = '{1, 1, 1, 2, 4, 8};
    chk("divchg t1", 32'(leds), 32'(exp_seq[0]));
    wr(2'd1, 32'd0);
    for (int t = 1; t < 6; t++) begin
      chk($sformatf("divchg t%0d", t + 1), 32'(leds), 32'(exp_seq[t]));
      @(negedge clk);
    end

    // Mid-run disable.
    run_check("rot_pre_dis", 1, 5'b00101, 0, 1'b0, 0, 3);
    rd_chk("run ctrl read", 2'd0, 32'h23);
    wr(2'd0, 32'h2);
    chk("disable busy", 32'(busy), 32'h0);
    chk("disable done", 32'(done), 32'h0);
    chk("disable leds", 32'(leds), 32'h05);
    rd_chk("disable ctrl read", 2'd0, 32'h02);

    // Reset pulse mid-run.
    run_check("rot_pre_rst", 1, 5'b00011, 1, 1'b0, 0, 4);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst leds", 32'(leds), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    rd_chk("rst div", 2'd1, 32'h5);
    rd_chk("rst pattern", 2'd2, 32'h1);
    rd_chk("rst ctrl", 2'd0, 32'h0);
    @(negedge clk);
    chk("rst leds after", 32'(leds), 32'h1);

    for (int r = 0; r < 20; r++) begin
      int mode, div, steps, pat;
      bit os;
      mode  = int'($urandom_range(0, 3));
      div   = int'($urandom_range(0, 3));
      os    = 1'($urandom_range(0, 1));
      steps = int'($urandom_range(0, 6));
      pat   = (mode == 2) ? (1 << $urandom_range(0, 4)) : int'($urandom_range(0, 31));
      run_check($sformatf("rand%0d", r), mode, pat, div, os, steps, (steps + 2) * (div + 1) + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
